// File: rtl/hsem_multi.sv
// Hardware semaphore engine: NUM_SEM semaphores shared by NUM_CORE masters, with
// two-step/one-step lock, owner-checked unlock, keyed clear-all, per-core intr/err.
module hsem_multi #(
  parameter int          NUM_SEM  = 32,
  parameter int          NUM_CORE = 2,
  parameter int          CORE_W   = 2,
  parameter logic [15:0] CLR_KEY  = 16'hA5A5
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [8:0]          reg_addr,
  input  logic [31:0]         ihwdata,
  input  logic [CORE_W-1:0]   core_id,
  output logic [31:0]         ihrdata,
  output logic [NUM_CORE-1:0] intr,
  output logic [NUM_CORE-1:0] err
);

  typedef struct packed {
    logic       lock;
    logic [7:0] coreid;
    logic [7:0] procid;
  } sem_t;

  sem_t [NUM_SEM-1:0]                  sem_q, sem_d;
  logic [NUM_CORE-1:0][NUM_SEM-1:0]    ier_q, ier_d, isr_q, isr_d, icr_clr;
  logic [NUM_CORE-1:0][2:0]            esr_q, esr_d;
  logic [NUM_SEM-1:0]                  free_set;
  logic [2:0]                          esr_set;
  logic [31:0]                         rdata;
  logic [7:0]                          cid8;
  logic [4:0]                          idx;
  logic                                aligned, sel_r, sel_rlr, sel_core, sel_cr;

  assign cid8     = 8'(core_id);
  assign idx      = reg_addr[6:2];
  assign aligned  = (reg_addr[1:0] == 2'b00);
  assign sel_r    = aligned && (reg_addr[8:7] == 2'b00);
  assign sel_rlr  = aligned && (reg_addr[8:7] == 2'b01);
  assign sel_core = aligned && (reg_addr[8:7] == 2'b10) && !reg_addr[6];
  assign sel_cr   = aligned && (reg_addr[8:7] == 2'b10) && (reg_addr[6:2] == 5'b10000);

  always_comb begin
    sem_d    = sem_q;
    ier_d    = ier_q;
    esr_d    = esr_q;
    isr_d    = isr_q;
    icr_clr  = '0;
    free_set = '0;
    esr_set  = 3'b000;
    rdata    = 32'h0;

    for (int i = 0; i < NUM_SEM; i++) begin
      if (idx == 5'(i)) begin
        if (wr_en && sel_r) begin
          // A COREID field that does not name the issuing master voids the access.
          if (ihwdata[15:8] != cid8) begin
            esr_set[1] = 1'b1;
          end else if (ihwdata[31]) begin
            if (!sem_q[i].lock) sem_d[i] = {1'b1, ihwdata[15:8], ihwdata[7:0]};
          end else if (sem_q[i].lock && sem_q[i].coreid == cid8 &&
                       sem_q[i].procid == ihwdata[7:0]) begin
            sem_d[i]    = '0;
            free_set[i] = 1'b1;
          end else begin
            esr_set[0] = 1'b1;
          end
        end
        if (rd_en && sel_r) rdata = {sem_q[i].lock, 15'b0, sem_q[i].coreid, sem_q[i].procid};
        if (rd_en && sel_rlr) begin
          if (sem_q[i].lock) begin
            rdata = {sem_q[i].lock, 15'b0, sem_q[i].coreid, sem_q[i].procid};
          end else begin
            sem_d[i] = {1'b1, cid8, 8'h00};
            rdata    = {1'b1, 15'b0, cid8, 8'h00};
          end
        end
      end
    end

    for (int c = 0; c < NUM_CORE; c++) begin
      if (sel_core && reg_addr[5:4] == 2'(c)) begin
        if (wr_en) begin
          case (reg_addr[3:2])
            2'd0:    ier_d[c]   = ihwdata[NUM_SEM-1:0];
            2'd1:    icr_clr[c] = ihwdata[NUM_SEM-1:0];
            2'd3:    esr_d[c]   = esr_q[c] & ~ihwdata[2:0];
            default: ;
          endcase
        end
        if (rd_en) begin
          case (reg_addr[3:2])
            2'd0:    rdata = 32'(ier_q[c]);
            2'd2:    rdata = 32'(isr_q[c]);
            2'd3:    rdata = 32'(esr_q[c]);
            default: rdata = 32'h0;
          endcase
        end
      end
    end

    if (wr_en && sel_cr) begin
      if (ihwdata[31:16] == CLR_KEY) begin
        for (int i = 0; i < NUM_SEM; i++) begin
          if (sem_q[i].lock && sem_q[i].coreid == ihwdata[15:8]) begin
            sem_d[i]    = '0;
            free_set[i] = 1'b1;
          end
        end
      end else begin
        esr_set[2] = 1'b1;
      end
    end

    // Free events are broadcast to every core and win over a same-cycle ICR clear.
    for (int c = 0; c < NUM_CORE; c++) begin
      isr_d[c] = (isr_q[c] & ~icr_clr[c]) | free_set;
      if (core_id == CORE_W'(c)) esr_d[c] = esr_d[c] | esr_set;
    end
  end

  always_comb begin
    intr = '0;
    err  = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      intr[c] = |(isr_q[c] & ier_q[c]);
      err[c]  = |esr_q[c];
    end
  end

  assign ihrdata = rdata;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      sem_q <= '0;
      ier_q <= '0;
      isr_q <= '0;
      esr_q <= '0;
    end else begin
      sem_q <= sem_d;
      ier_q <= ier_d;
      isr_q <= isr_d;
      esr_q <= esr_d;
    end
  end

endmodule

// File: tb/tb_hsem_multi.sv
// Bench for hsem_multi: directed walk of the main scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural semaphore model.
module tb_hsem_multi;
  localparam int NS = 32;
  localparam int NC = 2;
  localparam int CW = 2;

  logic          hclk = 1'b0;
  logic          hreset = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [8:0]    reg_addr = '0;
  logic [31:0]   ihwdata = '0;
  logic [CW-1:0] core_id = '0;
  logic [31:0]   ihrdata;
  logic [NC-1:0] intr, err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 hclk = ~hclk;

  hsem_multi #(.NUM_SEM(NS), .NUM_CORE(NC), .CORE_W(CW), .CLR_KEY(16'hA5A5)) dut (
    .hclk(hclk), .hreset(hreset), .wr_en(wr_en), .rd_en(rd_en), .reg_addr(reg_addr),
    .ihwdata(ihwdata), .core_id(core_id), .ihrdata(ihrdata), .intr(intr), .err(err)
  );

  // Behavioural model: plain per-semaphore arrays plus per-core words.
  bit          m_lock [NS];
  logic [7:0]  m_own  [NS];
  logic [7:0]  m_proc [NS];
  logic [31:0] m_ier  [NC];
  logic [31:0] m_isr  [NC];
  logic [2:0]  m_esr  [NC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] semval(input int i);
    return {m_lock[i], 15'b0, m_own[i], m_proc[i]};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_lock[i] = 1'b0; m_own[i] = 8'h0; m_proc[i] = 8'h0;
    end
    for (int c = 0; c < NC; c++) begin
      m_ier[c] = '0; m_isr[c] = '0; m_esr[c] = '0;
    end
  endfunction

  function automatic void model_free(input int i);
    m_lock[i] = 1'b0; m_own[i] = 8'h0; m_proc[i] = 8'h0;
    for (int c = 0; c < NC; c++) m_isr[c][i] = 1'b1;
  endfunction

  function automatic logic [31:0] exp_rd();
    int a, i, c;
    a = int'(reg_addr);
    if (!rd_en) return 32'h0;
    if (a < 'h80) begin
      i = a / 4;
      return (i < NS) ? semval(i) : 32'h0;
    end
    if (a < 'h100) begin
      i = (a - 'h80) / 4;
      if (i >= NS) return 32'h0;
      return m_lock[i] ? semval(i) : {1'b1, 15'b0, 8'(core_id), 8'h00};
    end
    if (a < 'h100 + 16 * NC) begin
      c = (a - 'h100) / 16;
      case ((a % 16) / 4)
        0: return m_ier[c];
        2: return m_isr[c];
        3: return 32'(m_esr[c]);
        default: return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d, input int cid);
    int i, c;
    logic [7:0] c8;
    c8 = 8'(cid);
    if (a < 'h80) begin
      i = a / 4;
      if (i < NS) begin
        if (d[15:8] != c8) m_esr[cid][1] = 1'b1;
        else if (d[31]) begin
          if (!m_lock[i]) begin
            m_lock[i] = 1'b1; m_own[i] = d[15:8]; m_proc[i] = d[7:0];
          end
        end else if (m_lock[i] && m_own[i] == c8 && m_proc[i] == d[7:0]) model_free(i);
        else m_esr[cid][0] = 1'b1;
      end
    end else if (a >= 'h100 && a < 'h100 + 16 * NC) begin
      c = (a - 'h100) / 16;
      case ((a % 16) / 4)
        0: m_ier[c] = d;
        1: m_isr[c] = m_isr[c] & ~d;
        3: m_esr[c] = m_esr[c] & ~d[2:0];
        default: ;
      endcase
    end else if (a == 'h140) begin
      if (d[31:16] == 16'hA5A5) begin
        for (int k = 0; k < NS; k++)
          if (m_lock[k] && m_own[k] == d[15:8]) model_free(k);
      end else m_esr[cid][2] = 1'b1;
    end
  endfunction

  function automatic void model_rlock(input int a, input int cid);
    int i;
    if (a >= 'h80 && a < 'h100) begin
      i = (a - 'h80) / 4;
      if (i < NS && !m_lock[i]) begin
        m_lock[i] = 1'b1; m_own[i] = 8'(cid); m_proc[i] = 8'h00;
      end
    end
  endfunction

  always @(posedge hclk) begin
    if (hreset) model_reset();
    else if (wr_en) model_write(int'(reg_addr), ihwdata, int'(core_id));
    else if (rd_en) model_rlock(int'(reg_addr), int'(core_id));
  end

  // Single compare process, mid-cycle, away from the active edge.
  always @(negedge hclk) begin
    logic [NC-1:0] ei, ee;
    if (chk_en) begin
      for (int c = 0; c < NC; c++) begin
        ei[c] = |(m_isr[c] & m_ier[c]);
        ee[c] = |m_esr[c];
      end
      check("ihrdata", ihrdata, exp_rd());
      check("intr", 32'(intr), 32'(ei));
      check("err", 32'(err), 32'(ee));
    end
  end

  task automatic acc(input bit w, input bit r, input int a, input logic [31:0] d, input int cid);
    wr_en = w; rd_en = r; reg_addr = 9'(a); ihwdata = d; core_id = CW'(cid);
    @(posedge hclk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input int cid);
    acc(1'b1, 1'b0, a, d, cid);
  endtask

  task automatic rdchk(input string name, input int a, input int cid, input logic [31:0] want);
    wr_en = 1'b0; rd_en = 1'b1; reg_addr = 9'(a); ihwdata = '0; core_id = CW'(cid);
    #2;
    check(name, ihrdata, want);
    @(posedge hclk); #1;
    rd_en = 1'b0;
  endtask

  initial begin
    int sel, i, cid, a;
    bit b31, w;
    logic [7:0] own, prc;
    logic [31:0] d;

    model_reset();
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1 hreset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_intr", 32'(intr), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    for (int k = 0; k < NS; k++) rdchk("rst_R", 4 * k, 0, 32'h0);
    rdchk("rst_isr0", 'h108, 0, 32'h0);
    rdchk("rst_esr0", 'h10C, 0, 32'h0);
    rdchk("rst_isr1", 'h118, 1, 32'h0);
    rdchk("rst_esr1", 'h11C, 1, 32'h0);

    // Two-step lock, contention
    wr('h00C, 32'h8000_0107, 1);
    rdchk("lock_R3", 'h00C, 0, 32'h8000_0107);
    wr('h00C, 32'h8000_0005, 0);
    rdchk("contend_R3", 'h00C, 0, 32'h8000_0107);
    check("contend_err", 32'(err), 32'h0);

    // One-step lock
    rdchk("rlr5_c0", 'h094, 0, 32'h8000_0000);
    rdchk("R5_after", 'h014, 1, 32'h8000_0000);
    rdchk("rlr5_c1", 'h094, 1, 32'h8000_0000);
    rdchk("R5_kept", 'h014, 1, 32'h8000_0000);
    rdchk("rlr31_c1", 'h0FC, 1, 32'h8000_0100);

    // Unlock raises ISR on every core, intr only where enabled
    wr('h110, 32'h8, 1);
    wr('h00C, 32'h0000_0107, 1);
    check("unl_intr", 32'(intr), 32'h2);
    rdchk("unl_R3", 'h00C, 1, 32'h0);
    rdchk("unl_isr1", 'h118, 1, 32'h8);
    rdchk("unl_isr0", 'h108, 0, 32'h8);
    wr('h114, 32'h8, 1);
    check("icr_intr", 32'(intr), 32'h0);
    wr('h104, 32'h8, 0);
    rdchk("icr_isr0", 'h108, 0, 32'h0);
    rdchk("icr_rd0", 'h104, 0, 32'h0);

    // Foreign COREID field -> ESR bit1
    wr('h00C, 32'h0000_0107, 0);
    check("cid_err", 32'(err), 32'h1);
    rdchk("cid_esr0", 'h10C, 0, 32'h2);
    wr('h10C, 32'h2, 0);
    check("esrclr_err", 32'(err), 32'h0);

    // Clear-all with good and bad key
    wr('h008, 32'h8000_0100, 1);
    wr('h01C, 32'h8000_0100, 1);
    rdchk("ca_R7", 'h01C, 0, 32'h8000_0100);
    wr('h140, 32'hA5A5_0100, 0);
    rdchk("ca_R2", 'h008, 0, 32'h0);
    rdchk("ca_R7b", 'h01C, 0, 32'h0);
    rdchk("ca_R5", 'h014, 0, 32'h8000_0000);
    rdchk("ca_R31", 'h07C, 0, 32'h0);
    rdchk("ca_isr0", 'h108, 0, 32'h8000_0084);
    rdchk("ca_isr1", 'h118, 1, 32'h8000_0084);
    wr('h140, 32'h1234_0100, 0);
    rdchk("key_esr0", 'h10C, 0, 32'h4);
    check("key_err", 32'(err), 32'h1);

    // Wrong PROCID on unlock -> ESR bit0
    wr('h024, 32'h8000_0005, 0);
    wr('h024, 32'h0000_0006, 0);
    rdchk("proc_R9", 'h024, 0, 32'h8000_0005);
    rdchk("proc_esr0", 'h10C, 0, 32'h5);
    wr('h10C, 32'h7, 0);
    check("proc_err", 32'(err), 32'h0);

    // Unmapped / write-only
    rdchk("cr_rd", 'h140, 0, 32'h0);
    rdchk("unmap_180", 'h180, 0, 32'h0);
    rdchk("unmap_core2", 'h128, 0, 32'h0);

    // Random traffic; compare process does the checking
    for (int n = 0; n < 4000; n++) begin
      sel = $urandom_range(0, 99);
      cid = $urandom_range(0, NC - 1);
      i = $urandom_range(0, 9);
      if (i > 7) i = $urandom_range(0, NS - 1);
      if (sel == 0) begin
        hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0;
      end else if (sel < 35) begin
        b31 = 1'($urandom_range(0, 1));
        own = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 3)) : 8'(cid);
        prc = 8'($urandom_range(0, 3));
        wr(4 * i, {b31, 15'b0, own, prc}, cid);
      end else if (sel < 55) begin
        acc(1'b0, 1'b1, 'h80 + 4 * i, 32'h0, cid);
      end else if (sel < 65) begin
        acc(1'b0, 1'b1, 4 * i, 32'h0, cid);
      end else if (sel < 85) begin
        a = 'h100 + 16 * $urandom_range(0, 3) + 4 * $urandom_range(0, 3);
        w = 1'($urandom_range(0, 1));
        d = $urandom();
        acc(w, !w, a, d, cid);
      end else if (sel < 93) begin
        d = {($urandom_range(0, 4) == 0) ? 16'($urandom()) : 16'hA5A5,
             8'($urandom_range(0, NC - 1)), 8'($urandom())};
        wr('h140, d, cid);
      end else if (sel < 97) begin
        acc(1'b0, 1'b0, 0, 32'h0, cid);
      end else begin
        w = 1'($urandom_range(0, 1));
        acc(w, !w, 4 * $urandom_range(0, 127), $urandom(), cid);
      end
    end

    @(posedge hclk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
